// File: rtl/load_req_unit.sv
// Load request unit: queues core loads, issues them one at a time to data memory
// and returns the results in request order through a one-entry response buffer.
`ifndef REG_LEN
`define REG_LEN 32
`endif
`ifndef MEMD_SIZE
`define MEMD_SIZE 8
`endif

module load_req_unit #(
  parameter int REG_LEN = `REG_LEN,
  parameter int ADDR_W  = `MEMD_SIZE,
  parameter int TAG_W   = 4,
  parameter int QDEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [TAG_W-1:0]   req_tag,
  output logic               req_ready,
  input  logic               flush,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_valid,
  input  logic               mem_ready,
  input  logic [REG_LEN-1:0] mem_data,
  input  logic               mem_out_valid,
  output logic               resp_valid,
  output logic [REG_LEN-1:0] resp_data,
  output logic [TAG_W-1:0]   resp_tag,
  input  logic               resp_ready,
  output logic               o_dbg_state
);

  // Valid/ready: a transfer happens on a posedge where both are high; the valid
  // side keeps its payload stable until then. mem_out_valid is a one-cycle strobe
  // with no ready.

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(QDEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_drop;
  logic   w_drop_nxt;
  logic   w_complete;

  logic [ADDR_W-1:0]  r_q_addr [QDEPTH];
  logic [TAG_W-1:0]   r_q_tag  [QDEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [TAG_W-1:0]   r_out_tag;
  logic               r_resp_valid;
  logic [REG_LEN-1:0] r_resp_data;
  logic [TAG_W-1:0]   r_resp_tag;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == DEPTH_CNT);
  assign w_empty = (r_count == '0);

  assign req_ready = !rst && !w_full && !flush;
  // Issue is held off while a result waits, so the response buffer never overwrites.
  assign mem_valid = !rst && (r_state == S_IDLE) && !w_empty && !r_resp_valid
                     && mem_ready && !flush;
  assign mem_addr  = (r_state == S_IDLE) ? r_q_addr[r_rd_ptr] : r_mem_addr;

  assign w_push = req_valid && req_ready;
  assign w_pop  = mem_valid;

  assign resp_valid  = r_resp_valid;
  assign resp_data   = r_resp_data;
  assign resp_tag    = r_resp_tag;
  assign o_dbg_state = r_state;

  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    w_complete  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (mem_valid) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mem_out_valid) begin
          w_state_nxt = S_IDLE;
          w_drop_nxt  = 1'b0;
          w_complete  = !r_drop && !flush;
        end else if (flush) begin
          w_drop_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        r_q_addr[i] <= '0;
        r_q_tag[i]  <= '0;
      end
    end else if (w_push) begin
      r_q_addr[r_wr_ptr] <= req_addr;
      r_q_tag[r_wr_ptr]  <= req_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_addr <= '0;
      r_out_tag  <= '0;
    end else if (mem_valid) begin
      r_mem_addr <= r_q_addr[r_rd_ptr];
      r_out_tag  <= r_q_tag[r_rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_tag   <= '0;
    end else if (flush) begin
      r_resp_valid <= 1'b0;
    end else if (w_complete) begin
      r_resp_valid <= 1'b1;
      r_resp_data  <= mem_data;
      r_resp_tag   <= r_out_tag;
    end else if (r_resp_valid && resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_load_req_unit.sv
// Bench for load_req_unit: memory model with latency addr+1, directed scenarios,
// and a randomized run checked against an in-order expected-result queue.
module tb_load_req_unit;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int TW = 4;
  localparam int QD = 4;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic [AW-1:0] req_addr;
  logic [TW-1:0] req_tag;
  logic          req_ready;
  logic          flush;
  logic [AW-1:0] mem_addr;
  logic          mem_valid;
  logic          mem_ready;
  logic [DW-1:0] mem_data;
  logic          mem_out_valid;
  logic          resp_valid;
  logic [DW-1:0] resp_data;
  logic [TW-1:0] resp_tag;
  logic          resp_ready;
  logic          dbg_state;
  logic          m_out_valid;
  logic          inj_out_valid;

  int checks;
  int errors;
  int hold_viol;
  logic [DW-1:0]    memarr [256];
  logic [TW+DW-1:0] pend_q[$];
  logic [TW+DW-1:0] exp_q[$];
  logic [TW+DW-1:0] got_q[$];

  assign mem_out_valid = m_out_valid | inj_out_valid;

  load_req_unit #(.REG_LEN(DW), .ADDR_W(AW), .TAG_W(TW), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_tag(req_tag), .req_ready(req_ready), .flush(flush),
    .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_data(mem_data), .mem_out_valid(mem_out_valid),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_tag(resp_tag),
    .resp_ready(resp_ready), .o_dbg_state(dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  // Data memory: an issue seen in cycle c returns data in cycle c+addr+1.
  initial begin
    logic          iss;
    logic [AW-1:0] iss_addr;
    logic          pend;
    int            left;
    logic [DW-1:0] pdata;
    m_out_valid = 1'b0;
    mem_data    = '0;
    pend        = 1'b0;
    left        = 0;
    pdata       = '0;
    forever begin
      @(negedge clk);
      iss      = mem_valid;
      iss_addr = mem_addr;
      @(posedge clk);
      #1;
      m_out_valid = 1'b0;
      if (iss) begin
        pend  = 1'b1;
        left  = int'(iss_addr) + 1;
        pdata = memarr[iss_addr];
      end
      if (pend) begin
        left--;
        if (left == 0) begin
          m_out_valid = 1'b1;
          mem_data    = pdata;
          pend        = 1'b0;
        end
      end
    end
  end

  // Reference model: accepted loads in order, squashed by flush/rst; records pairs.
  initial begin
    logic          h_prev;
    logic [DW-1:0] h_data;
    logic [TW-1:0] h_tag;
    h_prev    = 1'b0;
    h_data    = '0;
    h_tag     = '0;
    hold_viol = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_q.delete();
        h_prev = 1'b0;
      end else begin
        if (h_prev && (resp_valid !== 1'b1 || resp_data !== h_data || resp_tag !== h_tag))
          hold_viol++;
        if (resp_valid && resp_ready) begin
          got_q.push_back({resp_tag, resp_data});
          if (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
          else exp_q.push_back('1);
        end
        if (flush) pend_q.delete();
        if (req_valid && req_ready) pend_q.push_back({req_tag, memarr[req_addr]});
        h_prev = resp_valid && !resp_ready && !flush;
        h_data = resp_data;
        h_tag  = resp_tag;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_addr = 8'd3; req_tag = 4'd2;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (mem_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_valid: got %0b want 0", mem_valid); end
      checks++;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %0b want 0", req_ready); end
      @(posedge clk); #1;
    end
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || resp_data !== '0 || resp_tag !== '0) begin
      errors++; $display("FAIL reset_resp: got v=%0b d=%h t=%h want 0/0/0", resp_valid, resp_data, resp_tag);
    end
    checks++;
    if (mem_addr !== '0 || mem_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mem: got addr=%h v=%0b want 0/0", mem_addr, mem_valid);
    end
    checks++;
    if (req_ready !== 1'b1 || dbg_state !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got ready=%0b state=%0b want 1/0", req_ready, dbg_state);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_latency(input logic [AW-1:0] a, input logic [TW-1:0] t, input string nm);
    int out_c;
    out_c = 1 + int'(a) + 1;
    mem_ready = 1'b1; resp_ready = 1'b1;
    req_valid = 1'b1; req_addr = a; req_tag = t;
    for (int c = 0; c < out_c + 3; c++) begin
      if (c == 1) req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_valid !== 1'(c == 1)) begin
        errors++; $display("FAIL %s_mem_valid c%0d: got %0b want %0b", nm, c, mem_valid, c == 1);
      end
      if (c == 1) begin
        checks++;
        if (mem_addr !== a) begin errors++; $display("FAIL %s_mem_addr: got %h want %h", nm, mem_addr, a); end
      end
      checks++;
      if (mem_out_valid !== 1'(c == out_c)) begin
        errors++; $display("FAIL %s_out_valid c%0d: got %0b want %0b", nm, c, mem_out_valid, c == out_c);
      end
      checks++;
      if (resp_valid !== 1'(c == out_c + 1)) begin
        errors++; $display("FAIL %s_resp_valid c%0d: got %0b want %0b", nm, c, resp_valid, c == out_c + 1);
      end
      if (c == out_c + 1) begin
        checks++;
        if (resp_data !== memarr[a] || resp_tag !== t) begin
          errors++; $display("FAIL %s_resp: got d=%h t=%h want d=%h t=%h", nm, resp_data, resp_tag, memarr[a], t);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_queue_full();
    logic [TW-1:0] tags [5];
    logic [TW-1:0] got [$];
    logic [TW-1:0] base;
    base = TW'($urandom_range(0, 15));
    mem_ready = 1'b0; resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tags[i] = base + TW'(i);
      req_valid = 1'b1; req_addr = AW'($urandom_range(0, 5)); req_tag = tags[i];
      @(negedge clk);
      checks++;
      if (req_ready !== 1'(i < 4)) begin
        errors++; $display("FAIL full_req_ready push%0d: got %0b want %0b", i, req_ready, i < 4);
      end
      checks++;
      if (mem_valid !== 1'b0) begin errors++; $display("FAIL full_stall_issue: got %0b want 0", mem_valid); end
      @(posedge clk); #1;
    end
    req_valid = 1'b0; mem_ready = 1'b1;
    for (int c = 0; c < 150 && got.size() < 4; c++) begin
      @(negedge clk);
      if (resp_valid && resp_ready) got.push_back(resp_tag);
      @(posedge clk); #1;
    end
    checks++;
    if (got.size() != 4) begin errors++; $display("FAIL full_resp_count: got %0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== tags[i]) begin errors++; $display("FAIL full_order %0d: got %h want %h", i, got[i], tags[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [TW-1:0] ta, tb;
    logic [DW-1:0] da, db;
    bit seen;
    ta = TW'($urandom_range(0, 15)); tb = ta + 4'd5;
    da = memarr[1]; db = memarr[2];
    mem_ready = 1'b1; resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 8'd1; req_tag = ta;
    @(posedge clk); #1;
    req_addr = 8'd2; req_tag = tb;
    @(posedge clk); #1;
    req_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL bp_first_resp: got none want resp_valid within 40 cycles"); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== da || resp_tag !== ta) begin
        errors++; $display("FAIL bp_hold c%0d: got v=%0b d=%h t=%h want 1/%h/%h", c, resp_valid, resp_data, resp_tag, da, ta);
      end
      checks++;
      if (mem_valid !== 1'b0) begin errors++; $display("FAIL bp_no_issue c%0d: got %0b want 0", c, mem_valid); end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1;
        checks++;
        if (resp_data !== db || resp_tag !== tb) begin
          errors++; $display("FAIL bp_second: got d=%h t=%h want d=%h t=%h", resp_data, resp_tag, db, tb);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL bp_second_resp: got none want resp_valid within 40 cycles"); end
  endtask

  task automatic test_flush_wait();
    mem_ready = 1'b1; resp_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      case (c)
        0: begin req_valid = 1'b1; req_addr = 8'd6; req_tag = 4'd1; end
        1: begin req_addr = 8'd3; req_tag = 4'd2; end
        2: begin req_addr = 8'd4; req_tag = 4'd3; end
        3: req_valid = 1'b0;
        4: flush = 1'b1;
        5: flush = 1'b0;
        12: begin req_valid = 1'b1; req_addr = 8'd1; req_tag = 4'd9; end
        13: req_valid = 1'b0;
        default: ;
      endcase
      @(negedge clk);
      if (c == 4) begin
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_req_ready: got %0b want 0", req_ready); end
      end
      if (c >= 4 && c <= 12) begin
        checks++;
        if (mem_valid !== 1'b0) begin errors++; $display("FAIL flush_queue_empty c%0d: got mem_valid %0b want 0", c, mem_valid); end
      end
      if (c >= 4 && c <= 15) begin
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL flush_no_resp c%0d: got %0b want 0", c, resp_valid); end
      end
      if (c == 9) begin
        checks++;
        if (dbg_state !== 1'b0) begin errors++; $display("FAIL flush_back_idle: got %0b want 0", dbg_state); end
      end
      if (c == 13) begin
        checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 8'd1) begin
          errors++; $display("FAIL flush_new_issue: got v=%0b a=%h want 1/01", mem_valid, mem_addr);
        end
      end
      if (c == 16) begin
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== memarr[1] || resp_tag !== 4'd9) begin
          errors++; $display("FAIL flush_new_resp: got v=%0b d=%h t=%h want 1/%h/9", resp_valid, resp_data, resp_tag, memarr[1]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush_coincident();
    mem_ready = 1'b1; resp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      case (c)
        0: begin req_valid = 1'b1; req_addr = 8'd3; req_tag = 4'd4; end
        1: req_valid = 1'b0;
        5: flush = 1'b1;
        6: flush = 1'b0;
        7: begin req_valid = 1'b1; req_addr = 8'd0; req_tag = 4'd6; end
        8: req_valid = 1'b0;
        default: ;
      endcase
      @(negedge clk);
      if (c == 5) begin
        checks++;
        if (mem_out_valid !== 1'b1) begin errors++; $display("FAIL coinc_setup: got out_valid %0b want 1", mem_out_valid); end
      end
      if (c >= 6 && c <= 9) begin
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL coinc_no_resp c%0d: got %0b want 0", c, resp_valid); end
      end
      if (c == 10) begin
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== memarr[0] || resp_tag !== 4'd6) begin
          errors++; $display("FAIL coinc_next_resp: got v=%0b d=%h t=%h want 1/%h/6", resp_valid, resp_data, resp_tag, memarr[0]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_spurious();
    inj_out_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (dbg_state !== 1'b0) begin errors++; $display("FAIL spur_idle: got %0b want 0", dbg_state); end
    @(posedge clk); #1;
    inj_out_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || dbg_state !== 1'b0) begin
        errors++; $display("FAIL spur_ignored c%0d: got v=%0b state=%0b want 0/0", c, resp_valid, dbg_state);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_wait();
    mem_ready = 1'b1; resp_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      case (c)
        0: begin req_valid = 1'b1; req_addr = 8'd8; req_tag = 4'd7; end
        1: req_valid = 1'b0;
        3: begin rst = 1'b1; req_valid = 1'b1; end
        5: begin rst = 1'b0; req_valid = 1'b0; end
        default: ;
      endcase
      @(negedge clk);
      if (c == 2) begin
        checks++;
        if (dbg_state !== 1'b1) begin errors++; $display("FAIL rstw_in_wait: got %0b want 1", dbg_state); end
      end
      if (c == 3 || c == 4) begin
        checks++;
        if (mem_valid !== 1'b0 || req_ready !== 1'b0) begin
          errors++; $display("FAIL rstw_during: got v=%0b ready=%0b want 0/0", mem_valid, req_ready);
        end
      end
      if (c >= 5) begin
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL rstw_no_resp c%0d: got %0b want 0", c, resp_valid); end
      end
      if (c == 10) begin
        checks++;
        if (mem_out_valid !== 1'b1) begin errors++; $display("FAIL rstw_late_data: got %0b want 1", mem_out_valid); end
      end
      if (c == 13) begin
        checks++;
        if (resp_data !== '0 || resp_tag !== '0 || mem_addr !== '0 || mem_valid !== 1'b0
            || req_ready !== 1'b1 || dbg_state !== 1'b0) begin
          errors++; $display("FAIL rstw_outputs: got d=%h t=%h a=%h v=%0b r=%0b s=%0b want 0/0/0/0/1/0",
                             resp_data, resp_tag, mem_addr, mem_valid, req_ready, dbg_state);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    bit quiet;
    for (int c = 0; c < 500; c++) begin
      req_valid  = 1'($urandom_range(0, 1));
      req_addr   = AW'($urandom_range(0, 7));
      req_tag    = TW'($urandom_range(0, 15));
      mem_ready  = ($urandom_range(0, 3) != 0);
      resp_ready = ($urandom_range(0, 9) < 6);
      flush      = ($urandom_range(0, 99) < 3);
      @(negedge clk);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; flush = 1'b0; mem_ready = 1'b1; resp_ready = 1'b1;
    quiet = 1'b0;
    for (int c = 0; c < 400 && !quiet; c++) begin
      @(negedge clk);
      quiet = (pend_q.size() == 0) && !resp_valid && (dbg_state == 1'b0);
      @(posedge clk); #1;
    end
    checks++;
    if (!quiet) begin errors++; $display("FAIL rand_drain: got %0d loads outstanding want 0", pend_q.size()); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL sb_count: got %0d responses want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL sb_resp %0d: got {tag,data}=%h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (hold_viol !== 0) begin errors++; $display("FAIL sb_hold: got %0d unstable held responses want 0", hold_viol); end
  endtask

  initial begin
    checks = 0; errors = 0;
    for (int i = 0; i < 256; i++) memarr[i] = $urandom();
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_tag = '0; flush = 1'b0;
    mem_ready = 1'b1; resp_ready = 1'b1; inj_out_valid = 1'b0;
    memarr[2] = 32'h2A;
    test_reset();
    test_latency(8'd2, 4'd5, "lat_addr2");
    test_latency(8'd0, 4'd1, "lat_addr0");
    test_queue_full();
    test_backpressure();
    test_flush_wait();
    test_flush_coincident();
    test_spurious();
    test_reset_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_req_unit.md
LOAD_REQ_UNIT -- requirements
Module: load_req_unit

Interface
REQ-001 SHALL have parameter REG_LEN, default `REG_LEN, meaning data word width.
REQ-002 SHALL have parameter ADDR_W, default `MEMD_SIZE, meaning data-memory address width.
REQ-003 SHALL have parameter TAG_W, default 4, meaning load destination tag width.
REQ-004 SHALL have parameter QDEPTH, default 4, meaning request queue entries (power of 2).
REQ-005 clk  input  1  clock; all state updates on posedge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 req_valid  input  1  core presents a load.
REQ-008 req_addr  input  ADDR_W  load address.
REQ-009 req_tag  input  TAG_W  load destination tag.
REQ-010 req_ready  output  1  queue can accept; load accepted when req_valid && req_ready.
REQ-011 flush  input  1  squash all pending and in-flight loads.
REQ-012 mem_addr  output  ADDR_W  address to data memory.
REQ-013 mem_valid  output  1  issue strobe to data memory.
REQ-014 mem_ready  input  1  data memory can accept an issue.
REQ-015 mem_data  input  REG_LEN  read data from memory.
REQ-016 mem_out_valid  input  1  single-cycle read-data strobe, no backpressure.
REQ-017 resp_valid  output  1  load result available.
REQ-018 resp_data  output  REG_LEN  load result.
REQ-019 resp_tag  output  TAG_W  tag of the result.
REQ-020 resp_ready  input  1  core consumes result when resp_valid && resp_ready.

Function
REQ-021 Queue SHALL be FIFO of QDEPTH {addr,tag} entries; req_ready = !full && !flush (combinational).
REQ-022 Push and pop in the same cycle SHALL both take effect; pointers wrap modulo QDEPTH.
REQ-023 FSM states: IDLE, WAIT; at most one load outstanding at memory.
REQ-024 mem_valid SHALL equal (state==IDLE) && !empty && !resp_valid && mem_ready && !flush.
REQ-025 In IDLE, mem_addr SHALL equal queue-head address; in WAIT it SHALL hold the last issued address (never 0-forced).
REQ-026 On mem_valid: pop head, latch its tag into out_tag, go WAIT next cycle.
REQ-027 In WAIT on mem_out_valid with drop==0: next cycle resp_valid=1, resp_data=mem_data, resp_tag=out_tag; FSM to IDLE.
REQ-028 resp_valid, resp_data, resp_tag SHALL hold stable until resp_valid && resp_ready, then resp_valid clears next cycle.
REQ-029 New issue SHALL not occur while resp_valid=1 (one-entry response buffer, no overwrite).
REQ-030 flush SHALL empty the queue next cycle and clear resp_valid next cycle.
REQ-031 flush in WAIT (or in the issuing cycle's successor) SHALL set drop; the matching mem_out_valid is discarded, drop cleared, FSM to IDLE.
REQ-032 flush coincident with mem_out_valid SHALL discard that data.
REQ-033 mem_out_valid in IDLE SHALL be ignored.
REQ-034 Loads SHALL complete and respond in request order.

Reset
REQ-035 On rst: queue empty, state IDLE, drop=0, resp_valid=0, resp_data=0, resp_tag=0, mem_addr register=0, out_tag=0.
REQ-036 During rst, mem_valid=0 and req_ready=0; rst mid-WAIT abandons the load and later mem_out_valid is ignored.

Verification
REQ-037 Memory model latency addr+1: req addr=2 tag=5 at cycle 0, mem holds 0x2A -> mem_valid cycle 1, mem_out_valid cycle 4, resp_valid cycle 5 data=0x2A tag=5.
REQ-038 Addr 0 tag 1 -> mem_out_valid one cycle after issue, resp_valid two cycles after issue.
REQ-039 Five consecutive req_valid with memory stalled (mem_ready=0) -> four accepted, req_ready=0 on the fifth; release -> responses tags in push order.
REQ-040 resp_ready=0 for 10 cycles with two queued loads -> second mem_valid not asserted until first response consumed; data unchanged while held.
REQ-041 flush in WAIT with two queued -> no resp_valid for in-flight load, queue empty, next new request issues normally.
REQ-042 rst asserted in WAIT, then mem_out_valid -> resp_valid stays 0, all outputs at reset values.
